// File: rtl/stream_switch.sv
// 1-to-2 stream switch: routes packets to q0/q1 by s sampled at packet start, with a one-entry output buffer.
// Optional per-port completed-packet counters are enabled with `define SWITCH_PKT_COUNT_EN.
module stream_switch #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             d_last,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             s,
  output logic [WIDTH-1:0] q0,
  output logic             q0_last,
  output logic             q0_valid,
  input  logic             q0_ready,
  output logic [WIDTH-1:0] q1,
  output logic             q1_last,
  output logic             q1_valid,
  input  logic             q1_ready,
`ifdef SWITCH_PKT_COUNT_EN
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t           r_state;
  logic             r_buf_valid;
  logic             r_buf_port;
  logic [WIDTH-1:0] r_buf_data;
  logic             r_buf_last;

  logic w_sel_ready;
  logic w_drain;
  logic w_accept;
  logic w_port;

  // Only the ready of the port holding the buffered beat matters (head-of-line by design).
  assign w_sel_ready = r_buf_port ? q1_ready : q0_ready;
  assign w_drain     = r_buf_valid & w_sel_ready;
  assign d_ready     = rst_n & (~r_buf_valid | w_sel_ready);
  assign w_accept    = d_valid & d_ready;
  assign w_port      = (r_state == IDLE) ? s : (r_state == LOCK1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_buf_valid <= 1'b0;
      r_buf_port  <= 1'b0;
      r_buf_data  <= '0;
      r_buf_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf_valid <= 1'b1;
        r_buf_port  <= w_port;
        r_buf_data  <= d;
        r_buf_last  <= d_last;
        if (d_last)
          r_state <= IDLE;
        else
          r_state <= w_port ? LOCK1 : LOCK0;
      end else if (w_drain) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  assign q0_valid = r_buf_valid & ~r_buf_port;
  assign q1_valid = r_buf_valid & r_buf_port;
  assign q0       = q0_valid ? r_buf_data : '0;
  assign q1       = q1_valid ? r_buf_data : '0;
  assign q0_last  = q0_valid & r_buf_last;
  assign q1_last  = q1_valid & r_buf_last;
  assign busy     = (r_state != IDLE) | r_buf_valid;

`ifdef SWITCH_PKT_COUNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // A packet completes when its last beat leaves the buffer; counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_drain && r_buf_last) begin
      if (r_buf_port)
        r_cnt1 <= r_cnt1 + 1'b1;
      else
        r_cnt0 <= r_cnt0 + 1'b1;
    end
  end

  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;
`endif

endmodule
